// File: rtl/dec_bin_encoder_if.sv
// Digit-entry and result bus for the decimal-to-binary encoder.
interface dec_bin_encoder_if;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic       commit;
  logic       clear;
  logic [7:0] bin_out;
  logic       bin_valid;
  logic       overflow;
  logic       bad_digit;
  logic [1:0] digit_count;

  modport master (
    output digit_in, digit_valid, commit, clear,
    input  digit_ready, bin_out, bin_valid, overflow, bad_digit, digit_count
  );

  modport slave (
    input  digit_in, digit_valid, commit, clear,
    output digit_ready, bin_out, bin_valid, overflow, bad_digit, digit_count
  );
endinterface

// File: rtl/dec_bin_encoder.sv
// Serial BCD digit entry (MSD first) accumulated as acc*10+digit, emitted as a
// saturated 8-bit value with overflow and bad-digit flags on commit.
module dec_bin_encoder #(
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned ACC_WIDTH  = 10
) (
  input  logic clock,
  input  logic reset_n,
  dec_bin_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

  localparam logic [1:0]           MAX_CNT  = 2'(MAX_DIGITS);
  localparam logic [ACC_WIDTH-1:0] BYTE_MAX = ACC_WIDTH'(255);

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [1:0]           count;
  logic [3:0]           hold;
  logic                 pending;
  logic                 bad;
  logic                 ready;
  logic                 accept;
  logic [7:0]           bin_q;
  logic                 valid_q;
  logic                 ovf_q;
  logic                 bad_q;

  // Ready is gated by reset and clear so no digit is taken while either is active.
  always_comb begin
    ready    = reset_n && !bus.clear && (state == IDLE) && (count < MAX_CNT);
    accept   = ready && bus.digit_valid;
    acc_next = (acc << 3) + (acc << 1) + ACC_WIDTH'(hold);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      hold    <= '0;
      pending <= 1'b0;
      bad     <= 1'b0;
      bin_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.clear) begin
        state   <= IDLE;
        acc     <= '0;
        count   <= '0;
        pending <= 1'b0;
        bad     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              hold    <= bus.digit_in;
              pending <= bus.commit;
              state   <= ACC;
            end else if (bus.commit) begin
              state <= EMIT;
            end
          end
          ACC: begin
            if (hold <= 4'd9) acc <= acc_next;
            else              bad <= 1'b1;
            count   <= count + 2'd1;
            pending <= 1'b0;
            // A commit arriving during ACC is folded straight into the next-state choice.
            state   <= (pending || bus.commit) ? EMIT : IDLE;
          end
          EMIT: begin
            bin_q   <= (acc > BYTE_MAX) ? 8'hFF : acc[7:0];
            ovf_q   <= (acc > BYTE_MAX);
            bad_q   <= bad;
            valid_q <= 1'b1;
            acc     <= '0;
            count   <= '0;
            pending <= 1'b0;
            bad     <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.digit_ready = ready;
  assign bus.bin_out     = bin_q;
  assign bus.bin_valid   = valid_q;
  assign bus.overflow    = ovf_q;
  assign bus.bad_digit   = bad_q;
  assign bus.digit_count = count;

endmodule

// File: doc/dec_bin_encoder.md
Name: dec_bin_encoder

Overview:
- Serial decimal-entry to binary converter; the reverse direction of the display path's binary-to-3-digit-decimal decode.
- Accepts BCD digits most-significant first over a valid/ready handshake and accumulates acc = acc*10 + digit.
- On a commit pulse, emits the 8-bit binary value with saturation and error flags.
- Sits between keypad/UART digit sources and the CPU I/O port that takes an 8-bit operand.

Parameters:
- MAX_DIGITS, 3, maximum digits accepted per number.
- ACC_WIDTH, 10, accumulator width; must hold 10^MAX_DIGITS-1 (999).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- digit_in  input  4  BCD digit, MSD first.
- digit_valid  input  1  digit_in is valid.
- digit_ready  output  1  block can accept a digit this cycle.
- commit  input  1  single-cycle pulse; finish the current number.
- clear  input  1  synchronous abort of the current entry.
- bin_out  output  8  converted value, held until the next result.
- bin_valid  output  1  one-cycle pulse when bin_out updates.
- overflow  output  1  value exceeded 255; valid with bin_out.
- bad_digit  output  1  a digit >9 was received in this number; valid with bin_out.
- digit_count  output  2  digits accumulated so far.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; acc=0; count=0; pending=0; bad=0.
  - bin_out=0, bin_valid=0, overflow=0, bad_digit=0.
  - digit_ready=0 while reset is asserted; 1 in the first cycle after release.
- State machine:
  - States: IDLE, ACC, EMIT.
- IDLE:
  - digit_ready = (count < MAX_DIGITS).
  - On digit_valid && digit_ready: latch digit into hold, go to ACC.
- ACC (1 cycle, digit_ready=0):
  - If hold <= 9: acc <= acc*10 + hold, computed as (acc<<3)+(acc<<1)+hold, truncated to ACC_WIDTH.
  - If hold > 9: acc unchanged and bad <= 1.
  - count increments in both cases.
  - Next state: EMIT if pending, else IDLE.
  - Maximum digit throughput is 1 per 2 cycles.
- Commit:
  - In IDLE with no digit accepted that cycle: go to EMIT next cycle.
  - In the same cycle as a digit acceptance, or while in ACC: set pending; the digit is processed first, then EMIT.
  - Commit while in EMIT is ignored.
- EMIT (1 cycle, digit_ready=0), registered outputs:
  - bin_out <= (acc>255) ? 8'hFF : acc[7:0].
  - overflow <= (acc>255).
  - bad_digit <= bad.
  - bin_valid <= 1 for exactly one cycle.
  - acc, count, bad, pending cleared; return to IDLE.
  - bin_out, overflow and bad_digit are stable until the next EMIT.
- Commit with count=0 emits bin_out=0, overflow=0, bad_digit=0.
- Count full (count == MAX_DIGITS): digit_ready=0 and digits stall until commit or clear. Further digits are never dropped silently.
- clear:
  - Highest synchronous priority in any state.
  - acc, count, bad, pending cleared; state=IDLE; no bin_valid pulse.
  - bin_out, overflow, bad_digit hold their previous values.
  - A digit offered in the clear cycle is not accepted: digit_ready is forced 0 that cycle.
- Reset mid-entry (any state): all state is lost immediately; no output pulse.
- digit_count reflects count; it updates the cycle after ACC.

Test Plan:
- Digits 1,2,3 then commit → one bin_valid pulse, bin_out=8'd123, overflow=0, bad_digit=0; digit_count goes 1,2,3, then 0 after EMIT.
- Digits 2,5,6 then commit → bin_out=8'hFF, overflow=1; next entry 2,5,5 → bin_out=8'd255, overflow=0.
- Digits 4, 4'hB, 7 then commit → bin_out=8'd47, bad_digit=1; a following entry "9" → bin_out=9, bad_digit=0.
- Commit asserted in the same cycle as acceptance of the final digit of "8","6" → pending path taken; exactly one bin_valid, bin_out=86.
- Four digits offered back-to-back (1,0,0,5): 4th held with digit_ready=0 until commit → bin_out=100; then "5" is accepted; commit → 5. Also commit with no digits → bin_out=0, one pulse.
- reset_n pulled low while in ACC after "7","7", and clear asserted after "3": neither produces bin_valid; the subsequent "4"+commit → bin_out=4, with bin_out holding its prior value until then.
